// File: rtl/seq_mult_comp_if.sv
// rtl/seq_mult_comp_if.sv - switch/button/LED bundle for the sequential multiply-and-compare unit
interface seq_mult_comp_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH:0]     sw;
  logic [2:0]         btn;
  logic [2:0]         led;
  logic               busy;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] res;

  // Board/bench side: drives switches and buttons, observes results
  modport master (output sw, output btn, input led, input busy, input prod, input res);
  // Unit side
  modport slave  (input sw, input btn, output led, output busy, output prod, output res);
endinterface

// File: rtl/seq_mult_comp.sv
// rtl/seq_mult_comp.sv - shift-add multiplier with committed-result compare; CMP_SIGNED_EN selects signed arithmetic
module seq_mult_comp #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  seq_mult_comp_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  logic [0:0]       state;
  logic [2:0]       btn_q;
  logic             tog_q;
  logic [2:0]       rise;
  logic             tog;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    prod_fin;
  logic [CW-1:0]    cnt;
  logic             last_iter;

  logic [PW-1:0]    prod_r;
  logic [PW-1:0]    res_r;
  logic             prod_valid;
  logic             commit_pend;
  logic             lt;
  logic             eq;
  logic             gt;

  assign rise      = bus.btn & ~btn_q;
  assign tog       = bus.sw[WIDTH] ^ tog_q;
  assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef CMP_SIGNED_EN
  logic neg;

  // Magnitudes of the loaded operands; -2^(WIDTH-1) maps onto 2^(WIDTH-1), which still fits
  always_comb begin
    mag_a = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    mag_b = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
  end

  // Re-apply the sign on the completion cycle so latency matches the unsigned build
  always_comb begin
    prod_fin = neg ? (~acc_next + 1'b1) : acc_next;
  end

  // Two's complement compare of committed result against latest product
  always_comb begin
    lt = $signed(res_r) <  $signed(prod_r);
    gt = $signed(res_r) >  $signed(prod_r);
    eq = (res_r == prod_r);
  end

  // Sign of the running product, captured at start
  always_ff @(posedge clk) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (state == IDLE && rise[2]) begin
      neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
    end
  end
`else
  // Unsigned build: operands are their own magnitudes
  always_comb begin
    mag_a = op_a;
    mag_b = op_b;
  end

  // Unsigned build: accumulator is the product as-is
  always_comb begin
    prod_fin = acc_next;
  end

  // Unsigned compare of committed result against latest product
  always_comb begin
    lt = res_r <  prod_r;
    gt = res_r >  prod_r;
    eq = (res_r == prod_r);
  end
`endif

  // One shift-add step: multiplier sits in the low half of acc and is consumed LSB first
  always_comb begin
    sum      = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  // Edge detectors, operand registers, multiply FSM and commit logic
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q       <= bus.btn;
      tog_q       <= bus.sw[WIDTH];
      op_a        <= '0;
      op_b        <= '0;
      mcand       <= '0;
      acc         <= '0;
      cnt         <= '0;
      prod_r      <= '0;
      res_r       <= '0;
      prod_valid  <= 1'b0;
      commit_pend <= 1'b0;
      state       <= IDLE;
    end else begin
      btn_q <= bus.btn;
      tog_q <= bus.sw[WIDTH];
      if (rise[0]) op_a <= bus.sw[WIDTH-1:0];
      if (rise[1]) op_b <= bus.sw[WIDTH-1:0];

      case (state)
        IDLE: begin
          if (tog && prod_valid) res_r <= prod_r;
          if (rise[2]) begin
            mcand       <= mag_a;
            acc         <= {{WIDTH{1'b0}}, mag_b};
            cnt         <= '0;
            prod_valid  <= 1'b0;
            commit_pend <= 1'b0;
            state       <= MUL;
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (tog) commit_pend <= 1'b1;
          if (last_iter) begin
            prod_r      <= prod_fin;
            prod_valid  <= 1'b1;
            commit_pend <= 1'b0;
            if (commit_pend || tog) res_r <= prod_fin;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == MUL);
  assign bus.prod = prod_r;
  assign bus.res  = res_r;
  assign bus.led  = prod_valid ? {gt, eq, lt} : 3'b000;

endmodule

// File: tb/tb_seq_mult_comp.sv
// tb/tb_seq_mult_comp.sv - randomized and directed bench with a behavioural model of seq_mult_comp
module tb_seq_mult_comp;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  seq_mult_comp_if #(.WIDTH(W)) bus ();

  seq_mult_comp #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Behavioural model state
  logic [W-1:0]  m_a, m_b;
  logic [2:0]    m_btn_q;
  logic          m_tog_q;
  bit            m_busy, m_valid, m_pend;
  int            m_left;
  logic [PW-1:0] m_prod, m_res, m_target;

  function automatic logic [PW-1:0] ref_mult(logic [W-1:0] a, logic [W-1:0] b);
    longint pa, pb;
`ifdef CMP_SIGNED_EN
    pa = longint'($signed(a));
    pb = longint'($signed(b));
`else
    pa = longint'({1'b0, a});
    pb = longint'({1'b0, b});
`endif
    return PW'(pa * pb);
  endfunction

  function automatic logic [2:0] ref_led();
    if (!m_valid) return 3'b000;
`ifdef CMP_SIGNED_EN
    if ($signed(m_res) < $signed(m_prod)) return 3'b001;
    if ($signed(m_res) > $signed(m_prod)) return 3'b100;
`else
    if (m_res < m_prod) return 3'b001;
    if (m_res > m_prod) return 3'b100;
`endif
    return 3'b010;
  endfunction

  // Model: one step per rising edge, from the rules of operation
  always @(posedge clk) begin
    logic [2:0]   rise;
    logic         tog;
    logic [W-1:0] old_a, old_b;
    if (rst) begin
      m_btn_q = bus.btn;  m_tog_q = bus.sw[W];
      m_a = '0; m_b = '0; m_busy = 0; m_valid = 0; m_pend = 0; m_left = 0;
      m_prod = '0; m_res = '0; m_target = '0;
    end else begin
      rise = bus.btn & ~m_btn_q;
      tog  = bus.sw[W] ^ m_tog_q;
      m_btn_q = bus.btn;  m_tog_q = bus.sw[W];
      old_a = m_a;  old_b = m_b;
      if (rise[0]) m_a = bus.sw[W-1:0];
      if (rise[1]) m_b = bus.sw[W-1:0];
      if (!m_busy) begin
        if (tog && m_valid) m_res = m_prod;
        if (rise[2]) begin
          m_busy = 1; m_left = W; m_valid = 0; m_pend = 0;
          m_target = ref_mult(old_a, old_b);
        end
      end else begin
        if (tog) m_pend = 1;
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_prod = m_target; m_valid = 1;
          if (m_pend) m_res = m_prod;
          m_pend = 0;
        end
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge once out of the initial reset
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_busy", 64'(bus.busy), 64'(m_busy));
      check("model_prod", 64'(bus.prod), 64'(m_prod));
      check("model_res",  64'(bus.res),  64'(m_res));
      check("model_led",  64'(bus.led),  64'(ref_led()));
    end
  end

  task automatic load(int idx, logic [W-1:0] v);
    @(negedge clk); bus.sw[W-1:0] = v; bus.btn[idx] = 1'b1;
    @(negedge clk); bus.btn[idx] = 1'b0;
  endtask

  task automatic start();
    @(negedge clk); bus.btn[2] = 1'b1;
    @(negedge clk); bus.btn[2] = 1'b0;
  endtask

  task automatic toggle();
    @(negedge clk); bus.sw[W] = ~bus.sw[W];
    @(negedge clk);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 50) check("wait_idle_timeout", 64'(cycles), 64'(0));
  endtask

  initial begin
    int n;
    bus.sw  = '0;
    bus.btn = '0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_prod", 64'(bus.prod), 64'd0);
    check("reset_led",  64'(bus.led),  64'd0);
    rst = 1'b0;

    // 12 * 10
    load(0, 8'd12);
    load(1, 8'd10);
    start();
    wait_idle(n);
    check("busy_cycles", 64'(n), 64'(W));
    check("prod_120", 64'(bus.prod), 64'd120);
    check("res_0", 64'(bus.res), 64'd0);
    check("led_lt", 64'(bus.led), 64'b001);

    // Immediate commit, then a larger product
    toggle();
    check("res_120", 64'(bus.res), 64'd120);
    check("led_eq", 64'(bus.led), 64'b010);
    load(0, 8'd13);
    start();
    wait_idle(n);
    check("prod_130", 64'(bus.prod), 64'd130);
    check("led_lt_130", 64'(bus.led), 64'b001);

`ifndef CMP_SIGNED_EN
    load(0, 8'd255);
    load(1, 8'd255);
    start();
    wait_idle(n);
    check("prod_65025", 64'(bus.prod), 64'd65025);
`endif

    // Toggle and second start while busy
    load(0, 8'd7);
    load(1, 8'd9);
    start();
    @(negedge clk);
    toggle();
    bus.btn[2] = 1'b1;
    @(negedge clk); bus.btn[2] = 1'b0;
    wait_idle(n);
    check("pend_prod", 64'(bus.prod), 64'd63);
    check("pend_res", 64'(bus.res), 64'd63);
    check("pend_led", 64'(bus.led), 64'b010);
    @(negedge clk);
    check("no_queued_start", 64'(bus.busy), 64'd0);

    // Reset in the middle of a multiply with start held
    start();
    repeat (3) @(negedge clk);
    bus.btn[2] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_prod", 64'(bus.prod), 64'd0);
    check("rst_res",  64'(bus.res),  64'd0);
    check("rst_led",  64'(bus.led),  64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("held_start_ignored", 64'(bus.busy), 64'd0);
    bus.btn[2] = 1'b0;

`ifdef CMP_SIGNED_EN
    load(0, 8'hFD);
    load(1, 8'd5);
    start();
    wait_idle(n);
    check("prod_neg15", 64'(bus.prod), 64'hFFF1);
    check("led_gt", 64'(bus.led), 64'b100);
    load(0, 8'h80);
    load(1, 8'h80);
    start();
    wait_idle(n);
    check("prod_16384", 64'(bus.prod), 64'd16384);
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.sw[W-1:0] = W'($urandom);
      if ($urandom_range(0, 3) == 0) bus.btn = 3'($urandom);
      if ($urandom_range(0, 5) == 0) bus.sw[W] = ~bus.sw[W];
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.btn = '0;
    repeat (W + 2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_comp.md
# seq_mult_comp

Parametrised multi-cycle multiply-and-compare unit for the board-level arithmetic labs. Two WIDTH-bit operands are loaded from switches on button presses. A shift-add FSM multiplies them over WIDTH cycles. The new product is compared against a committed reference result, and the outcome drives three LEDs. It replaces the single-cycle combinational multiplier path with a sequential datapath, and adds button edge detection, a busy indication and optional signed arithmetic.

## Interface
- WIDTH, 8: operand width in bits, ≥2; product is 2*WIDTH bits.
- CW, $clog2(WIDTH+1): iteration counter width (derived).

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  WIDTH+1  sw[WIDTH-1:0] operand value; sw[WIDTH] commit toggle.
- btn  in  3  btn[0] load A, btn[1] load B, btn[2] start multiply; level inputs, edge-detected internally.
- led  out  3  led[0] res<prod, led[1] res==prod, led[2] res>prod.
- busy  out  1  high while the multiply FSM is in MUL.
- prod  out  2*WIDTH  latest completed product.
- res  out  2*WIDTH  committed reference result.

## Operation
- Edge detect: btn_q and tog_q registers sample btn and sw[WIDTH] every cycle. A rise is btn[i] & ~btn_q[i]. A toggle is sw[WIDTH] ^ tog_q.
- Operand load: a btn[0] rise sets op_a <= sw[WIDTH-1:0]; a btn[1] rise sets op_b likewise. Loads are accepted in any state. Simultaneous btn[0] and btn[1] rises load both registers.
- FSM states:
  - IDLE: a btn[2] rise copies op_a and op_b into working registers, clears prod_valid and cnt, and moves to MUL.
  - MUL: each cycle, if multiplier LSB=1, add multiplicand into the upper half of the accumulator, then shift right by one; cnt++.
  - MUL exit: when cnt==WIDTH-1 on this cycle, write the final accumulator to prod, set prod_valid=1 and return to IDLE.
- btn[2] rise while in MUL: ignored, not queued.
- Commit: a toggle seen in IDLE with prod_valid=1 sets res <= prod the next edge.
  - Toggle while busy sets commit_pend; commit happens on the completion edge using the new product.
  - Toggle while prod_valid=0 and IDLE is discarded.
- LEDs: when prod_valid=1, exactly one of led[2:0] is high, from comparing res against prod. When prod_valid=0, led=3'b000.
- Arithmetic: unsigned by default. Product is exact in 2*WIDTH bits, with no overflow possible.

## Timing
- Reset values: led=0, busy=0, prod=0, res=0, op_a=op_b=0, prod_valid=0, commit_pend=0, state=IDLE. btn_q is set to btn and tog_q to sw[WIDTH] at reset, so held inputs do not fire an edge.
- Start rise sampled at edge k: busy is high from after edge k through edge k+WIDTH.
  - prod and prod_valid are updated at edge k+WIDTH.
  - led reflects the new product from edge k+WIDTH.
  - Total latency: WIDTH cycles.
- Pending commit: res is updated at edge k+WIDTH, together with prod, so led shows == in that cycle.
- Immediate commit: a toggle sampled at edge j in IDLE updates res at edge j. Edge detect and commit are registered on the same edge, so the toggle is visible at edge j.
- Reset mid-MUL: the FSM returns to IDLE next edge. The partial product is discarded and prod stays 0.
- Back-to-back: a start rise in the IDLE cycle right after completion is accepted. There are no dead cycles.

## Configuration
- CMP_SIGNED_EN defined:
  - Operands, prod and res are two's complement.
  - Multiply takes absolute values of the working operands, runs WIDTH iterations, then negates the result if the signs differ. The negation is done in the same completion cycle, so latency is unchanged.
  - Comparison is signed.
  - Most-negative operand (-2^(WIDTH-1)) is supported. Its magnitude fits in WIDTH unsigned bits.
- Undefined: unsigned multiply and unsigned compare as above. No sign logic is synthesised.

## Test plan
- WIDTH=8. Load A=12, B=10, start. Required: busy high exactly 8 cycles, then prod=120. res=0 after reset, so led=3'b001.
- Toggle sw[8] in IDLE after that run. Required: res=120, led=3'b010. Then load A=13 and restart; after completion, prod=130, led=3'b001.
- A=B=255. Required: prod=65025, with no truncation.
- Start, then toggle sw[8] and pulse btn[2] mid-MUL. Required: the second start is ignored, and res=prod=product of the first run at completion.
- Assert rst at MUL cycle 4. Required: all outputs return to reset values next edge, and a held btn[2] does not restart after rst drops.
- CMP_SIGNED_EN defined: A=-3 (0xFD), B=5. Required: prod=16'hFFF1. With res=0, led=3'b100. Also A=-128, B=-128 gives prod=16384.
